// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bundle: decoded instruction fields from ID and their registered copies for EX.
// The decode side uses the master modport; the pipeline register uses the slave modport.
interface id_ex_stage_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_regWrite;
  logic        id_memRead;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;

  logic        ex_valid;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [15:0] ex_ctrl;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regWrite,
           id_memRead, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    input  ex_valid, ex_regWrite, ex_memRead, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_imm, ex_ctrl
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regWrite,
           id_memRead, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    output ex_valid, ex_regWrite, ex_memRead, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_imm, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, hold and flush handling.
// Optional load-use bubble counter enabled by defining ID_EX_STALL_COUNTER_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  id_ex_stage_if.slave bus,
  input  logic        hold,
  input  logic        flush,
`ifdef ID_EX_STALL_COUNTER_EN
  output logic [31:0] stall_count,
`endif
  output logic        stall_out
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } ex_t;

  ex_t  ex_q, ex_d, id_pkt;
  logic load_use;
  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit  = bus.id_rs1_used && (bus.id_rs1 == ex_q.rd);
    rs2_hit  = bus.id_rs2_used && (bus.id_rs2 == ex_q.rd);
    // A load targeting x0 never produces a value worth waiting for.
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.id_valid &&
               (rs1_hit || rs2_hit);
    stall_out = hold || (load_use && !flush);
  end

  always_comb begin
    id_pkt.valid     = bus.id_valid;
    id_pkt.reg_write = bus.id_valid & bus.id_regWrite;
    id_pkt.mem_read  = bus.id_valid & bus.id_memRead;
    id_pkt.rs1       = bus.id_rs1;
    id_pkt.rs2       = bus.id_rs2;
    id_pkt.rd        = bus.id_rd;
    id_pkt.rs1_data  = bus.id_rs1_data;
    id_pkt.rs2_data  = bus.id_rs2_data;
    id_pkt.imm       = bus.id_imm;
    id_pkt.ctrl      = bus.id_ctrl;

    ex_d = ex_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (flush || load_use) begin
      ex_d = '0;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_regWrite = ex_q.reg_write;
  assign bus.ex_memRead  = ex_q.mem_read;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_ctrl     = ex_q.ctrl;

`ifdef ID_EX_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!hold && !flush && load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic,
// all checked against a per-edge behavioural model of the pipeline register.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst, hold, flush, stall_out;
`ifdef ID_EX_STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .hold       (hold),
    .flush      (flush),
`ifdef ID_EX_STALL_COUNTER_EN
    .stall_count(stall_count),
`endif
    .stall_out  (stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [15:0] ctrl;
    logic [31:0] cnt;
  } model_t;

  model_t m;
  bit     m_init = 0;
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_load_use();
    bit dep;
    dep = (bus.id_rs1_used && bus.id_rs1 == m.rd) || (bus.id_rs2_used && bus.id_rs2 == m.rd);
    return m.valid && m.mr && (m.rd != 0) && bus.id_valid && dep;
  endfunction

  task automatic make_bubble();
    m.valid = 0; m.rw = 0; m.mr = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0;
    m.d1 = 0; m.d2 = 0; m.imm = 0; m.ctrl = 0;
  endtask

  // Apply this edge's priority: reset, hold, flush, load-use bubble, then normal capture.
  task automatic model_edge(input bit lu);
    if (rst) begin
      make_bubble();
      m.cnt = 0;
    end else if (hold) begin
      // registers keep their values
    end else if (flush) begin
      make_bubble();
    end else if (lu) begin
      make_bubble();
      if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
    end else begin
      m.valid = bus.id_valid;
      m.rw    = bus.id_valid && bus.id_regWrite;
      m.mr    = bus.id_valid && bus.id_memRead;
      m.rs1   = bus.id_rs1;  m.rs2 = bus.id_rs2;  m.rd = bus.id_rd;
      m.d1    = bus.id_rs1_data;  m.d2 = bus.id_rs2_data;
      m.imm   = bus.id_imm;  m.ctrl = bus.id_ctrl;
    end
  endtask

  task automatic check_ex();
    chk("ex_valid", bus.ex_valid, m.valid);
    chk("ex_regWrite", bus.ex_regWrite, m.rw);
    chk("ex_memRead", bus.ex_memRead, m.mr);
    chk("ex_rs1", bus.ex_rs1, m.rs1);
    chk("ex_rs2", bus.ex_rs2, m.rs2);
    chk("ex_rd", bus.ex_rd, m.rd);
    chk("ex_rs1_data", bus.ex_rs1_data, m.d1);
    chk("ex_rs2_data", bus.ex_rs2_data, m.d2);
    chk("ex_imm", bus.ex_imm, m.imm);
    chk("ex_ctrl", bus.ex_ctrl, m.ctrl);
`ifdef ID_EX_STALL_COUNTER_EN
    chk("stall_count", stall_count, m.cnt);
`endif
  endtask

  // Inputs are already driven; check stall_out, take one edge, check the registers.
  task automatic cycle();
    bit lu;
    #1;
    lu = model_load_use();
    if (m_init) chk("stall_out", stall_out, hold || (lu && !flush));
    @(posedge clk);
    model_edge(lu);
    if (rst) m_init = 1;
    #1;
    if (m_init) check_ex();
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input logic [4:0] rd, input bit rw, input bit mr,
                        input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid = v;  bus.id_rs1 = rs1;  bus.id_rs1_used = u1;
    bus.id_rs2 = rs2;  bus.id_rs2_used = u2;  bus.id_rd = rd;
    bus.id_regWrite = rw;  bus.id_memRead = mr;
    bus.id_rs1_data = d1;  bus.id_rs2_data = d2;
    bus.id_imm = d1 ^ d2;  bus.id_ctrl = d1[15:0];
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom_range(0, 2) == 0), $urandom, $urandom);
    bus.id_imm  = $urandom;
    bus.id_ctrl = 16'($urandom);
    hold  = ($urandom_range(0, 9) == 0);
    flush = ($urandom_range(0, 9) == 0);
    rst   = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    m = '{default: '0};
    rst = 1; hold = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle();
    rst = 0;
    chk("reset_stall_is_hold", stall_out, 1'b0);

    // Normal flow: rd=5, rs1_data=0x1234 captured in one cycle.
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 32'h1234, 32'h55);
    cycle();
    chk("normal_rd", bus.ex_rd, 32'd5);
    chk("normal_rs1_data", bus.ex_rs1_data, 32'h1234);
    chk("normal_valid", bus.ex_valid, 1'b1);

    // Load rd=7, then a consumer of rs2=7: one bubble, then it advances.
    set_id(1, 5'd3, 1, 5'd4, 0, 5'd7, 1, 1, 32'hA, 32'hB);
    cycle();
    set_id(1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0, 32'hC, 32'hD);
    #1;
    chk("lu_stall", stall_out, 1'b1);
    cycle();
    chk("lu_bubble", bus.ex_valid, 1'b0);
    cycle();
    chk("lu_adv_rs2", bus.ex_rs2, 32'd7);
    chk("lu_adv_valid", bus.ex_valid, 1'b1);
`ifdef ID_EX_STALL_COUNTER_EN
    chk("lu_count", stall_count, 32'd1);
`endif

    // rs2 not used against load rd=7; load rd=0 against rs1=0.
    set_id(1, 5'd3, 1, 5'd4, 0, 5'd7, 1, 1, 32'h1, 32'h2);
    cycle();
    set_id(1, 5'd1, 1, 5'd7, 0, 5'd9, 1, 0, 32'h3, 32'h4);
    cycle();
    chk("unused_rs2_adv", bus.ex_valid, 1'b1);
    set_id(1, 5'd3, 1, 5'd4, 0, 5'd0, 1, 1, 32'h5, 32'h6);
    cycle();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd10, 1, 0, 32'h7, 32'h8);
    cycle();
    chk("x0_load_adv", bus.ex_rd, 32'd10);

    // Load-use coincident with flush: no stall, bubble, counter unchanged.
    set_id(1, 5'd3, 1, 5'd4, 0, 5'd7, 1, 1, 32'h9, 32'hA);
    cycle();
    set_id(1, 5'd7, 1, 5'd4, 0, 5'd11, 1, 0, 32'hB, 32'hC);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_bubble", bus.ex_valid, 1'b0);

    // Hold for three cycles with ex_rd=9, then normal capture.
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 32'hD, 32'hE);
    cycle();
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd12, 1, 0, 32'hF, 32'h10);
    hold = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("hold_rd", bus.ex_rd, 32'd9);
    hold = 0;
    cycle();
    chk("after_hold_rd", bus.ex_rd, 32'd12);

    // Reset during a load-use stall drops the pending bubble.
    set_id(1, 5'd3, 1, 5'd4, 0, 5'd7, 1, 1, 32'h11, 32'h12);
    cycle();
    set_id(1, 5'd7, 1, 5'd4, 0, 5'd13, 1, 0, 32'h13, 32'h14);
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_valid", bus.ex_valid, 1'b0);
    cycle();
    chk("rst_no_residual", bus.ex_rd, 32'd13);

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
